// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer.
// A one-hot ring counter steps through the T-states T1..T6. The IR opcode is
// decoded into the active-low load/output enables that drive the 8-bit bus
// registers. Executing HLT parks the unit in a HALT state, and only a reset
// brings it back out.
module sap_control_sequencer (
  input  logic       clk,
  input  logic       low_reset,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       halted,
  output logic       pc_inc,
  output logic       low_pc_o_en,
  output logic       low_mar_i_en,
  output logic       low_ram_o_en,
  output logic       low_ir_i_en,
  output logic       low_ir_o_en,
  output logic       low_acc_i_en,
  output logic       low_acc_o_en,
  output logic       low_alu_o_en,
  output logic       alu_sub,
  output logic       low_b_i_en,
  output logic       low_out_i_en
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] ST_HALT = 6'b000000;
  localparam logic [5:0] ST_T1   = 6'b000001;
  localparam logic [5:0] ST_T2   = 6'b000010;
  localparam logic [5:0] ST_T3   = 6'b000100;
  localparam logic [5:0] ST_T4   = 6'b001000;
  localparam logic [5:0] ST_T5   = 6'b010000;
  localparam logic [5:0] ST_T6   = 6'b100000;

  logic [5:0] r_t_state;
  logic       r_halted;
  logic [5:0] w_ring_next;

  // Next ring position. Any illegal pattern falls back to T1 so the ring self-heals.
  always_comb begin
    case (r_t_state)
      ST_T1:   w_ring_next = ST_T2;
      ST_T2:   w_ring_next = ST_T3;
      ST_T3:   w_ring_next = ST_T4;
      ST_T4:   w_ring_next = ST_T5;
      ST_T5:   w_ring_next = ST_T6;
      default: w_ring_next = ST_T1;
    endcase
  end

  // Ring counter and halt flag. Reset takes priority over both HALT and run.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values. Blocking assignments here would create order-dependent races.
    if (!low_reset) begin
      r_t_state <= ST_T1;
      r_halted  <= 1'b0;
    end else if (!r_halted && run) begin
      if (r_t_state == ST_T4 && opcode == OP_HLT) begin
        r_t_state <= ST_HALT;
        r_halted  <= 1'b1;
      end else begin
        r_t_state <= w_ring_next;
      end
    end
  end

  logic w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_eu, w_su, w_lb, w_lo;

  // Control-word decode from the registered T-state and opcode (asserted = 1 here).
  always_comb begin
    // NOTE: every signal gets a default before the case. A path that left one
    // unassigned would infer a latch.
    w_cp = 1'b0; w_ep = 1'b0; w_lm = 1'b0; w_ce = 1'b0;
    w_li = 1'b0; w_ei = 1'b0; w_la = 1'b0; w_ea = 1'b0;
    w_eu = 1'b0; w_su = 1'b0; w_lb = 1'b0; w_lo = 1'b0;
    if (low_reset && !r_halted) begin
      case (r_t_state)
        ST_T1: begin
          w_ep = 1'b1;
          w_lm = 1'b1;
        end
        ST_T2: w_cp = 1'b1;
        ST_T3: begin
          w_ce = 1'b1;
          w_li = 1'b1;
        end
        ST_T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            w_ei = 1'b1;
            w_lm = 1'b1;
          end else if (opcode == OP_OUT) begin
            w_ea = 1'b1;
            w_lo = 1'b1;
          end
        end
        ST_T5: begin
          if (opcode == OP_LDA) begin
            w_ce = 1'b1;
            w_la = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            w_ce = 1'b1;
            w_lb = 1'b1;
            w_su = (opcode == OP_SUB);
          end
        end
        ST_T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            w_eu = 1'b1;
            w_la = 1'b1;
            // Subtract is held from T5 so the ALU has settled before ACC loads.
            w_su = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state      = r_t_state;
  assign halted       = r_halted;
  assign pc_inc       = w_cp;
  assign alu_sub      = w_su;
  assign low_pc_o_en  = ~w_ep;
  assign low_mar_i_en = ~w_lm;
  assign low_ram_o_en = ~w_ce;
  assign low_ir_i_en  = ~w_li;
  assign low_ir_o_en  = ~w_ei;
  assign low_acc_i_en = ~w_la;
  assign low_acc_o_en = ~w_ea;
  assign low_alu_o_en = ~w_eu;
  assign low_b_i_en   = ~w_lb;
  assign low_out_i_en = ~w_lo;

endmodule
